intersection_phase_scheduler: RTL
=================================

// Module: intersection_phase_scheduler
// PURPOSE
//  Sequences right-of-way at one intersection across three phases: main road (phase 0, rest phase),
//  side road (phase 1, sensor demand) and pedestrian walk (phase 2, button demand).
//  Latches requests, serves them round-robin under min/max green limits, and inserts yellow and all-red clearance.
//  Drives the lamp outputs directly. One clk cycle = 1 s.
// PARAMETERS
//  MIN_GREEN  6   minimum vehicle green, cycles
//  MAX_GREEN  12  maximum side green under continuous demand, cycles
//  YELLOW_T   2   yellow duration, cycles
//  ALL_RED_T  1   all-red clearance, cycles
//  WALK_T     5   walk phase duration, cycles
// PORTS
//  clk           in   1  system clock (1 Hz)
//  rst           in   1  synchronous, active-high reset
//  sensor        in   1  side-road vehicle present (level)
//  walk_button   in   1  pedestrian request (pulse or level)
//  main_light    out  2  main-road lamp: 00 RED, 01 YELLOW, 10 GREEN
//  side_light    out  2  side-road lamp, same encoding
//  walk_light    out  1  1 = walk
//  active_phase  out  2  phase currently green/walk; 3 during YELLOW/ALL_RED
// BEHAVIOUR
//  - Reset: on the next edge the block enters state GREEN with phase 0.
//    main_light=10, side_light=00, walk_light=0, active_phase=0, pend=000, timer=0.
//  - All outputs are registered. A decision made in cycle n is visible at edge n+1.
//  - States: GREEN(p), WALK, YELLOW, ALL_RED. Timer clears on every state entry and increments every cycle.
//  - Pending: pend[1] |= sensor; pend[2] |= walk_button.
//    Sensor is not latched while phase 1 is green. Walk_button is ignored during WALK.
//    pend[p] clears on the first cycle phase p is served.
//  - GREEN(0): holds indefinitely while pend==0.
//    Goes to YELLOW when pend!=0 and at least MIN_GREEN cycles of green have elapsed.
//  - GREEN(1): goes to YELLOW when either condition holds:
//    (a) at least MIN_GREEN cycles elapsed and sensor==0;
//    (b) exactly MAX_GREEN cycles elapsed.
//  - WALK: exactly WALK_T cycles, then ALL_RED with no yellow. Both vehicle lamps are RED.
//  - YELLOW: the lamp of the leaving phase = 01 for YELLOW_T cycles, then ALL_RED.
//  - ALL_RED: all lamps red, walk off, for ALL_RED_T cycles.
//    Then the next phase is chosen from (pend|req) in the final ALL_RED cycle, searching round-robin from last_phase+1.
//    If nothing is pending, phase 0 is chosen.
//  - Simultaneous side+walk requests: round-robin order decides; a pedestrian waits at most one side phase.
//  - Timer width is $clog2(max param)+1. It saturates and never wraps.
//  - rst mid-cycle overrides everything. Pending requests are discarded.
// CONFIGURATION
//  EMERGENCY_PREEMPT_EN defined:
//  - Adds input `preempt` (1 bit).
//  - While preempt==1 in GREEN(1) or WALK: leave immediately with no MIN_GREEN wait.
//    GREEN(1) goes through YELLOW; WALK goes straight to ALL_RED.
//  - After clearance, GREEN(0) is entered and held while preempt==1. pend is preserved.
//  - preempt during YELLOW/ALL_RED forces the next phase to 0.
//  EMERGENCY_PREEMPT_EN not defined: the port and all related logic are absent.
// STRUCTURE
//  - Package tl_pkg: LIGHT_RED/YELLOW/GREEN encodings, state enum, PH_MAIN/PH_SIDE/PH_WALK indices.
//  - Sub-module phase_timer: clearable, saturating up-counter that exposes its count.
//  - Round-robin select and FSM are in this module.
// TESTING
//  1. rst=1 for 1 cycle, then idle 20 cycles -> main GREEN throughout, side RED, walk 0.
//  2. sensor=1 held from cycle 10 after reset -> main YELLOW 2 cycles, ALL_RED 1, then side GREEN exactly 12 cycles.
//     Then side YELLOW 2, ALL_RED 1, then main GREEN.
//  3. walk_button pulsed 1 cycle at cycle 2 -> main stays green until 6 green cycles elapse, then YELLOW 2, ALL_RED 1.
//     Then walk_light=1 for 5 cycles, ALL_RED 1, then main GREEN.
//  4. sensor and walk_button together -> side served first, then walk, then main; each phase exactly once.
//  5. rst asserted during side GREEN -> next edge: main GREEN, pend=0.
//     A walk_button press before the reset is not served.
//  6. (EMERGENCY_PREEMPT_EN) preempt=1 at side-green cycle 2 -> side YELLOW next edge, then ALL_RED, then main GREEN held.
//     A pending walk is served after preempt drops and MIN_GREEN elapses.

Source files
------------

// File: rtl/intersection_phase_scheduler_pkg.sv
// Shared lamp encodings, phase indices and FSM state type for the intersection phase scheduler.
package tl_pkg;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_GREEN  = 2'b10;

    localparam logic [1:0] PH_MAIN  = 2'd0;
    localparam logic [1:0] PH_SIDE  = 2'd1;
    localparam logic [1:0] PH_WALK  = 2'd2;
    localparam logic [1:0] PH_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        StGreen,
        StWalk,
        StYellow,
        StAllRed
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Lamp for vehicle phase `own`, given the state and the phase being served or left.
    function automatic logic [1:0] lamp_for(input state_e st, input logic [1:0] ph,
                                            input logic [1:0] own);
        if (ph != own) return LIGHT_RED;
        if (st == StGreen) return LIGHT_GREEN;
        if (st == StYellow) return LIGHT_YELLOW;
        return LIGHT_RED;
    endfunction

endpackage

// File: rtl/intersection_phase_scheduler_if.sv
// Request inputs and lamp outputs of the scheduler; the optional preempt line exists only
// when EMERGENCY_PREEMPT_EN is defined.
interface intersection_phase_scheduler_if;
    logic       sensor;
    logic       walk_button;
`ifdef EMERGENCY_PREEMPT_EN
    logic       preempt;
`endif
    logic [1:0] main_light;
    logic [1:0] side_light;
    logic       walk_light;
    logic [1:0] active_phase;

`ifdef EMERGENCY_PREEMPT_EN
    modport master (output sensor, walk_button, preempt,
                    input  main_light, side_light, walk_light, active_phase);
    modport slave  (input  sensor, walk_button, preempt,
                    output main_light, side_light, walk_light, active_phase);
`else
    modport master (output sensor, walk_button,
                    input  main_light, side_light, walk_light, active_phase);
    modport slave  (input  sensor, walk_button,
                    output main_light, side_light, walk_light, active_phase);
`endif
endinterface

// File: rtl/intersection_phase_scheduler_phase_timer.sv
// Clearable saturating up-counter measuring cycles spent in the current scheduler state.
module phase_timer #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (count_q != '1) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Three-phase intersection scheduler (main rest phase, side sensor demand, pedestrian walk)
// with yellow/all-red clearance. Define EMERGENCY_PREEMPT_EN to add the preempt input.
module intersection_phase_scheduler
    import tl_pkg::*;
#(
    parameter int unsigned MIN_GREEN = 6,
    parameter int unsigned MAX_GREEN = 12,
    parameter int unsigned YELLOW_T  = 2,
    parameter int unsigned ALL_RED_T = 1,
    parameter int unsigned WALK_T    = 5
) (
    input logic                          clk,
    input logic                          rst,
    intersection_phase_scheduler_if.slave bus
);

    localparam int unsigned MaxParam =
        max_u(max_u(max_u(MIN_GREEN, MAX_GREEN), max_u(YELLOW_T, ALL_RED_T)), WALK_T);
    localparam int unsigned TW = $clog2(MaxParam) + 1;

    // Timer value during the last cycle of each interval.
    localparam logic [TW-1:0] MinLast  = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] MaxLast  = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] YelLast  = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] ArLast   = TW'(ALL_RED_T - 1);
    localparam logic [TW-1:0] WalkLast = TW'(WALK_T - 1);

    state_e       state_q, state_d;
    logic [1:0]   phase_q, phase_d;
    logic [2:0]   pend_q, pend_d;
    logic [1:0]   main_q, side_q, act_q;
    logic         walk_q;
    logic         leave;
    logic [1:0]   nxt;
    logic [TW-1:0] timer;
    logic         pre_now;
    logic         force_main;

    phase_timer #(
        .WIDTH (TW)
    ) u_phase_timer (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (leave),
        .count_o (timer)
    );

`ifdef EMERGENCY_PREEMPT_EN
    logic pre_q;

    assign pre_now    = bus.preempt;
    assign force_main = pre_q | bus.preempt;

    // Remembers a preempt seen anywhere in clearance so the next phase is forced to main.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= 1'b0;
        end else if (state_d == StYellow || state_d == StAllRed) begin
            pre_q <= pre_q | bus.preempt;
        end else begin
            pre_q <= 1'b0;
        end
    end
`else
    assign pre_now    = 1'b0;
    assign force_main = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        pend_d  = pend_q;
        leave   = 1'b0;
        nxt     = PH_MAIN;

        if (!(state_q == StGreen && phase_q == PH_SIDE)) pend_d[PH_SIDE] = pend_q[PH_SIDE] | bus.sensor;
        if (state_q != StWalk) pend_d[PH_WALK] = pend_q[PH_WALK] | bus.walk_button;

        unique case (state_q)
            StGreen: begin
                if (phase_q == PH_MAIN) begin
                    leave = (pend_q != '0) && (timer >= MinLast) && !pre_now;
                end else begin
                    leave = ((timer >= MinLast) && !bus.sensor) || (timer >= MaxLast) || pre_now;
                end
            end
            StWalk:   leave = (timer >= WalkLast) || pre_now;
            StYellow: leave = (timer >= YelLast);
            StAllRed: leave = (timer >= ArLast);
            default:  leave = 1'b0;
        endcase

        // Main is the rest phase and always a candidate, so a waiting pedestrian sees at most
        // one side phase first and the side road cannot be served twice in a row.
        unique case (phase_q)
            PH_MAIN: nxt = pend_d[PH_SIDE] ? PH_SIDE : (pend_d[PH_WALK] ? PH_WALK : PH_MAIN);
            PH_SIDE: nxt = pend_d[PH_WALK] ? PH_WALK : PH_MAIN;
            default: nxt = PH_MAIN;
        endcase
        if (force_main) nxt = PH_MAIN;

        if (leave) begin
            unique case (state_q)
                StGreen:          state_d = StYellow;
                StWalk, StYellow: state_d = StAllRed;
                default: begin
                    phase_d      = nxt;
                    state_d      = (nxt == PH_WALK) ? StWalk : StGreen;
                    pend_d[nxt]  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StGreen;
            phase_q <= PH_MAIN;
            pend_q  <= '0;
            main_q  <= LIGHT_GREEN;
            side_q  <= LIGHT_RED;
            walk_q  <= 1'b0;
            act_q   <= PH_MAIN;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            pend_q  <= pend_d;
            main_q  <= lamp_for(state_d, phase_d, PH_MAIN);
            side_q  <= lamp_for(state_d, phase_d, PH_SIDE);
            walk_q  <= (state_d == StWalk);
            act_q   <= (state_d == StGreen || state_d == StWalk) ? phase_d : PH_CLEAR;
        end
    end

    assign bus.main_light   = main_q;
    assign bus.side_light   = side_q;
    assign bus.walk_light   = walk_q;
    assign bus.active_phase = act_q;

endmodule
